store_write_buffer: RTL and testbench

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer.sv | 139 +++++++++++++
 tb/tb_store_write_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: a small in-order FIFO of processor stores that sits in front of
// data memory. The processor can store without waiting for memory, the buffer drains
// one entry per accepted memory handshake, and loads are forwarded from the youngest
// matching buffered store.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,   // power of two, 2..16
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,      // active-low, asynchronous
  // Processor store port
  input  logic                   MemWrite,
  input  logic [AW-1:0]          DataAdr,
  input  logic [DW-1:0]          WriteData,
  output logic                   stall,
  // Memory drain port
  output logic                   mem_valid,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ready,
  // Load forwarding
  input  logic [AW-1:0]          ld_addr,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data,
  // Status
  output logic [$clog2(DEPTH):0] count,
  output logic                   align_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry storage and bookkeeping
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             align_err_q, align_err_d;

  logic full, empty;
  logic push, pop, misaligned;
  logic [PW-1:0] fwd_idx;

  // Status flags come from the registered occupancy only
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
  end

  // Handshake decode: pushes are judged against the registered full flag, so a pop in
  // the same cycle never frees a slot for a store that is already stalled.
  always_comb begin
    stall      = MemWrite & full;
    push       = MemWrite & ~full & (DataAdr[1:0] == 2'b00);
    misaligned = MemWrite & ~full & (DataAdr[1:0] != 2'b00);
    pop        = ~empty & mem_ready;
  end

  // Memory side sees the registered head entry only; no bypass from the store port
  always_comb begin
    mem_valid = ~empty;
    mem_addr  = addr_q[rd_ptr_q];
    mem_wdata = data_q[rd_ptr_q];
    count     = count_q;
    align_err = align_err_q;
  end

  // Next-state for entries, pointers, occupancy and the sticky alignment flag
  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    align_err_d = align_err_q | misaligned;

    // Pop and push never target the same slot: that would need empty (no pop) or
    // full (no push).
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      addr_d[wr_ptr_q]  = DataAdr;
      data_d[wr_ptr_q]  = WriteData;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Forwarding: walk oldest to youngest from the read pointer so the last match wins.
  // Only registered entries take part; the head still counts in the cycle it pops.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // State registers; reset discards every buffered store immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '{default: '0};
      data_q      <= '{default: '0};
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      align_err_q <= align_err_d;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus a randomized phase, all
// outputs compared each cycle against a queue-based reference model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        stall;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;
  logic        align_err;

  store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .stall     (stall),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .count     (count),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an ordered queue of {addr, data} plus the sticky error flag
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t mdl_q[$];
  bit   mdl_align = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int          sz;
    logic        exp_hit;
    logic [31:0] exp_fd;
    sz = mdl_q.size();
    check("stall", 64'(stall), 64'(MemWrite && (sz == DEPTH)));
    check("count", 64'(count), 64'(sz));
    check("mem_valid", 64'(mem_valid), 64'(sz != 0));
    if (sz != 0) begin
      check("mem_addr", 64'(mem_addr), 64'(mdl_q[0].a));
      check("mem_wdata", 64'(mem_wdata), 64'(mdl_q[0].d));
    end
    exp_hit = 1'b0;
    exp_fd  = '0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (!exp_hit && mdl_q[i].a == ld_addr) begin
        exp_hit = 1'b1;
        exp_fd  = mdl_q[i].d;
      end
    end
    check("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
    check("fwd_data", 64'(fwd_data), 64'(exp_fd));
    check("align_err", 64'(align_err), 64'(mdl_align));
  endtask

  // Called right at the rising edge with the inputs that were presented for it
  task automatic model_update();
    int sz;
    bit full;
    sz   = mdl_q.size();
    full = (sz == DEPTH);
    if (sz != 0 && mem_ready) void'(mdl_q.pop_front());
    if (MemWrite && !full) begin
      if (DataAdr[1:0] == 2'b00) mdl_q.push_back({DataAdr, WriteData});
      else mdl_align = 1'b1;
    end
  endtask

  // One cycle: inputs already driven after a falling edge
  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mdl_q.delete();
    mdl_align = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int thresh;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    compare_all();
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single store, drained the next cycle
    mem_ready = 1'b1;
    store(32'd100, 32'd7);
    #1;
    check("single_valid", 64'(mem_valid), 64'd1);
    check("single_addr", 64'(mem_addr), 64'd100);
    check("single_data", 64'(mem_wdata), 64'd7);
    step();
    check("single_drained", 64'(count), 64'd0);

    // Fill to full, stall, then drain in order while the stalled store gets in
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'd80 + 32'(4 * i), 32'h100 + 32'(i));
    check("fill_count", 64'(count), 64'd4);
    MemWrite  = 1'b1;
    DataAdr   = 32'd96;
    WriteData = 32'h196;
    #1;
    check("fill_stall", 64'(stall), 64'd1);
    step();
    mem_ready = 1'b1;
    #1;
    check("pop_full_stall", 64'(stall), 64'd1);
    step();
    step();
    MemWrite = 1'b0;
    repeat (5) step();
    check("fill_drained", 64'(count), 64'd0);

    // Forwarding picks the youngest match
    mem_ready = 1'b0;
    store(32'd96, 32'd5);
    store(32'd96, 32'd9);
    ld_addr = 32'd96;
    #1;
    check("fwd_hit96", 64'(fwd_hit), 64'd1);
    check("fwd_data96", 64'(fwd_data), 64'd9);
    ld_addr = 32'd100;
    #1;
    check("fwd_hit100", 64'(fwd_hit), 64'd0);
    check("fwd_data100", 64'(fwd_data), 64'd0);
    mem_ready = 1'b1;
    repeat (3) step();

    // Steady push+pop at count 2 wraps the pointers
    mem_ready = 1'b0;
    store(32'd200, 32'hA0);
    store(32'd204, 32'hA1);
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      store(32'd208 + 32'(4 * i), 32'hB0 + 32'(i));
      check("concurrent_count", 64'(count), 64'd2);
    end
    repeat (3) step();

    // Misaligned store is dropped and sets the sticky flag
    store(32'd98, 32'h55);
    check("mis_count", 64'(count), 64'd0);
    check("mis_flag", 64'(align_err), 64'd1);
    repeat (5) step();
    check("mis_sticky", 64'(align_err), 64'd1);
    do_reset();
    #1;
    check("mis_cleared", 64'(align_err), 64'd0);
    @(negedge clk);

    // Randomized traffic in phases of differing memory back-pressure
    for (int ph = 0; ph < 3; ph++) begin
      thresh = 20 + 30 * ph;
      for (int c = 0; c < 200; c++) begin
        MemWrite  = ($urandom_range(0, 9) < 6);
        DataAdr   = ($urandom_range(0, 31) == 0) ? 32'd98 : 32'd80 + 32'(4 * $urandom_range(0, 5));
        WriteData = $urandom;
        ld_addr   = 32'd80 + 32'(4 * $urandom_range(0, 6));
        mem_ready = ($urandom_range(0, 99) < thresh);
        step();
      end
    end
    MemWrite  = 1'b0;
    mem_ready = 1'b1;
    repeat (5) step();
    do_reset();
    @(negedge clk);

    // Reset mid-drain takes effect without a clock edge
    mem_ready = 1'b0;
    store(32'd300, 32'h1);
    store(32'd304, 32'h2);
    store(32'd308, 32'h3);
    check("pre_rst_count", 64'(count), 64'd3);
    mem_ready = 1'b1;
    #2;
    reset = 1'b0;
    mdl_q.delete();
    mdl_align = 1'b0;
    #1;
    check("async_rst_valid", 64'(mem_valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      step();
      check("post_rst_idle", 64'(mem_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
